fifo_rd_crc_framer: RTL

//  Read-side consumer for the 32-bit FIFO. Pops words, groups every FRAME_LEN words into a frame,
//  and appends one CRC-32 word per frame. Emits a valid/ready stream to the downstream CRC

---
 rtl/fifo_rd_crc_framer.sv | 109 ++++++++++
 1 files changed

// File: rtl/fifo_rd_crc_framer.sv
// rtl/fifo_rd_crc_framer.sv - FIFO read-side framer: pops words, groups FRAME_LEN per frame, appends CRC-32/MPEG-2
module fifo_rd_crc_framer #(
  parameter int unsigned FRAME_LEN = 4,
  parameter logic [31:0] CRC_INIT  = 32'hFFFF_FFFF
) (
  input  logic        r_clk,
  input  logic        rrst_n,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_data,
  output logic        fifo_rd_en,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        m_is_crc,
  output logic [15:0] frame_cnt,
  output logic        busy
);
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [15:0] FLEN = 16'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;
  state_t state, state_nxt;

  logic [15:0] rd_cnt;
  logic [15:0] tx_cnt;
  logic [31:0] crc;
  logic [31:0] skid [3];
  logic [1:0]  occ;
  logic [1:0]  push_idx;
  logic        inflight;
  logic        start, xfer, data_xfer, crc_xfer, last_data;

  // Bit-serial CRC over one word, MSB (byte [31:24]) first.
  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
    end
    return r;
  endfunction

  always_comb begin
    // Issue gate counts the word already in flight so the skid never overflows.
    fifo_rd_en = (state == DATA) && !fifo_empty && (rd_cnt < FLEN)
               && (({1'b0, occ} + {2'b0, inflight}) < 3'd3);
    m_is_crc   = (state == CRC);
    m_last     = m_is_crc;
    m_valid    = ((state == DATA) && (occ != 2'd0)) || m_is_crc;
    m_data     = m_is_crc ? crc : (m_valid ? skid[0] : 32'h0);
    xfer       = m_valid && m_ready;
    data_xfer  = xfer && !m_is_crc;
    crc_xfer   = xfer && m_is_crc;
    last_data  = data_xfer && (tx_cnt == FLEN - 16'd1);
    start      = (state == IDLE) && en;
    push_idx   = data_xfer ? occ - 2'd1 : occ;
    busy       = (state != IDLE) || (occ != 2'd0) || inflight;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = DATA;
      DATA:    if (last_data) state_nxt = CRC;
      CRC:     if (crc_xfer) state_nxt = en ? DATA : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (!rrst_n) begin
      state     <= IDLE;
      rd_cnt    <= 16'd0;
      tx_cnt    <= 16'd0;
      crc       <= CRC_INIT;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      frame_cnt <= 16'd0;
      skid[0]   <= 32'h0;
      skid[1]   <= 32'h0;
      skid[2]   <= 32'h0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      if (data_xfer) begin
        skid[0] <= skid[1];
        skid[1] <= skid[2];
      end
      // Push after the shift so a same-cycle pop/push lands in the freed slot.
      if (inflight) skid[push_idx] <= fifo_data;
      occ <= occ + {1'b0, inflight} - {1'b0, data_xfer};

      if (start || crc_xfer) begin
        rd_cnt <= 16'd0;
        tx_cnt <= 16'd0;
        crc    <= CRC_INIT;
      end else begin
        if (fifo_rd_en) rd_cnt <= rd_cnt + 16'd1;
        if (data_xfer) begin
          tx_cnt <= tx_cnt + 16'd1;
          crc    <= crc_word(crc, m_data);
        end
      end
      if (crc_xfer) frame_cnt <= frame_cnt + 16'd1;
    end
  end
endmodule
